gcd_datapath: RTL and testbench

- Datapath partner of the GCD controller FSM. It accepts operand pairs on a valid/ready input handshake and holds the working X/Y registers.
- It executes one controller command per cycle (load, subtract, latch) and returns comparison status to the controller.
- It presents the finished GCD on a valid/ready output handshake.
- It sits between the operand source, the controller and the result consumer.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_operand_buf.sv | 35 +++
 rtl/gcd_datapath.sv | 100 ++++++++++
 tb/tb_gcd_datapath.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller/datapath pair: command encoding
// and the default operand width.
package gcd_pkg;

  localparam int GCD_W = 4;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_LOAD  = 3'd1;
  localparam logic [2:0] CMD_SUB_X = 3'd2;
  localparam logic [2:0] CMD_SUB_Y = 3'd3;
  localparam logic [2:0] CMD_LATCH = 3'd4;

endpackage

// File: rtl/gcd_operand_buf.sv
// Single-entry operand buffer. It holds one X/Y pair until the datapath loads it.
// Valid/ready: a pair transfers on a rising edge where in_valid && in_ready.
module gcd_operand_buf #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic         load,
  output logic         op_pending,
  output logic [W-1:0] op_x,
  output logic [W-1:0] op_y
);

  // A refill cannot happen in the same cycle as a load: ready comes only from the registered flag.
  assign in_ready = !op_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_pending <= 1'b0;
      op_x       <= '0;
      op_y       <= '0;
    end else if (load) begin
      op_pending <= 1'b0;
    end else if (in_valid && in_ready) begin
      op_pending <= 1'b1;
      op_x       <= x_in;
      op_y       <= y_in;
    end
  end

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath. It runs one controller command per cycle on the X/Y working
// registers and presents results on a valid/ready output (transfer on out_valid && out_ready).
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int W  = GCD_W,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x_in,
  input  logic [W-1:0]  y_in,
  input  logic [2:0]    cmd,
  output logic          op_pending,
  output logic          x_eq_y,
  output logic          x_gt_y,
  output logic          x_zero,
  output logic          y_zero,
  output logic          cmd_err,
  output logic [W-1:0]  gcd_out,
  output logic [CW-1:0] iter_out,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [CW-1:0] ITER_MAX = {CW{1'b1}};

  logic [W-1:0]  x_reg, y_reg;
  logic [W-1:0]  op_x, op_y;
  logic [CW-1:0] iter_cnt;
  logic          load_ok, sub_x_ok, sub_y_ok, latch_legal, latch_ok, err_next;
  logic [W-1:0]  result;

  gcd_operand_buf #(.W(W)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .y_in       (y_in),
    .load       (load_ok),
    .op_pending (op_pending),
    .op_x       (op_x),
    .op_y       (op_y)
  );

  assign x_eq_y = (x_reg == y_reg);
  assign x_gt_y = (x_reg > y_reg);
  assign x_zero = (x_reg == '0);
  assign y_zero = (y_reg == '0);

  // Legality checks keep the subtractions from underflowing.
  always_comb begin
    load_ok     = (cmd == CMD_LOAD) && op_pending;
    sub_x_ok    = (cmd == CMD_SUB_X) && x_gt_y && !y_zero;
    sub_y_ok    = (cmd == CMD_SUB_Y) && (x_reg < y_reg) && !x_zero;
    latch_legal = x_eq_y || x_zero || y_zero;
    latch_ok    = (cmd == CMD_LATCH) && latch_legal && (!out_valid || out_ready);
    err_next    = (cmd != CMD_NOP) && !(load_ok || sub_x_ok || sub_y_ok || latch_ok);
    result      = x_zero ? y_reg : x_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      iter_cnt <= '0;
    end else if (load_ok) begin
      x_reg    <= op_x;
      y_reg    <= op_y;
      iter_cnt <= '0;
    end else if (sub_x_ok || sub_y_ok) begin
      if (sub_x_ok) x_reg <= x_reg - y_reg;
      else          y_reg <= y_reg - x_reg;
      if (iter_cnt != ITER_MAX) iter_cnt <= iter_cnt + 1'b1;
    end
  end

  // A latch on the handshake cycle replaces the old result, so out_valid stays high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gcd_out   <= '0;
      iter_out  <= '0;
      out_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err <= err_next;
      if (latch_ok) begin
        gcd_out   <= result;
        iter_out  <= iter_cnt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed bench for gcd_datapath. It uses a 3-bit iteration counter so the
// saturation case stays short.
module tb_gcd_datapath;
  import gcd_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x_in = '0;
  logic [W-1:0]  y_in = '0;
  logic [2:0]    cmd = CMD_NOP;
  logic          op_pending, x_eq_y, x_gt_y, x_zero, y_zero, cmd_err;
  logic [W-1:0]  gcd_out;
  logic [CW-1:0] iter_out;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  gcd_datapath #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .cmd(cmd), .op_pending(op_pending),
    .x_eq_y(x_eq_y), .x_gt_y(x_gt_y), .x_zero(x_zero), .y_zero(y_zero),
    .cmd_err(cmd_err), .gcd_out(gcd_out), .iter_out(iter_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Drivers: inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    int waited = 0;
    while (!in_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL push_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; x_in = x; y_in = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] c);
    cmd = c;
    @(posedge clk); #1;
    cmd = CMD_NOP;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL consume_clear: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, op_pending, cmd_err, gcd_out, iter_out} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: ov=%0b pend=%0b err=%0b gcd=%0d iter=%0d rdy=%0b required 0/0/0/0/0/1",
               out_valid, op_pending, cmd_err, gcd_out, iter_out, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    push(4'd12, 4'd8);
    checks++;
    if (op_pending !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_capture: pend=%0b rdy=%0b required 1/0", op_pending, in_ready);
    end
    do_cmd(CMD_LOAD);
    checks++;
    if (dut.x_reg !== 4'd12 || dut.y_reg !== 4'd8 || x_gt_y !== 1'b1 || op_pending !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_load: x=%0d y=%0d gt=%0b pend=%0b rdy=%0b required 12/8/1/0/1",
               dut.x_reg, dut.y_reg, x_gt_y, op_pending, in_ready);
    end
    do_cmd(CMD_SUB_X);
    checks++;
    if (dut.x_reg !== 4'd4 || dut.y_reg !== 4'd8 || x_gt_y !== 1'b0 || x_eq_y !== 1'b0 || cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_sub_x: x=%0d y=%0d gt=%0b eq=%0b err=%0b required 4/8/0/0/0",
               dut.x_reg, dut.y_reg, x_gt_y, x_eq_y, cmd_err);
    end
    do_cmd(CMD_SUB_Y);
    checks++;
    if (dut.x_reg !== 4'd4 || dut.y_reg !== 4'd4 || x_eq_y !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_sub_y: x=%0d y=%0d eq=%0b ov=%0b required 4/4/1/0",
               dut.x_reg, dut.y_reg, x_eq_y, out_valid);
    end
    do_cmd(CMD_LATCH);
    checks++;
    if (out_valid !== 1'b1 || gcd_out !== 4'd4 || iter_out !== 3'd2 || cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_latch: ov=%0b gcd=%0d iter=%0d err=%0b required 1/4/2/0",
               out_valid, gcd_out, iter_out, cmd_err);
    end
    idle();
    checks++;
    if (out_valid !== 1'b1 || gcd_out !== 4'd4) begin
      failures++;
      $display("FAIL basic_hold: ov=%0b gcd=%0d required 1/4", out_valid, gcd_out);
    end
    consume();
  endtask

  task automatic test_zero_operands();
    push(4'd0, 4'd9);
    do_cmd(CMD_LOAD);
    checks++;
    if (x_zero !== 1'b1 || y_zero !== 1'b0 || x_gt_y !== 1'b0) begin
      failures++;
      $display("FAIL zero_flags: xz=%0b yz=%0b gt=%0b required 1/0/0", x_zero, y_zero, x_gt_y);
    end
    do_cmd(CMD_LATCH);
    checks++;
    if (out_valid !== 1'b1 || gcd_out !== 4'd9 || iter_out !== 3'd0) begin
      failures++;
      $display("FAIL zero_x_latch: ov=%0b gcd=%0d iter=%0d required 1/9/0", out_valid, gcd_out, iter_out);
    end
    consume();
    push(4'd0, 4'd0);
    do_cmd(CMD_LOAD);
    do_cmd(CMD_LATCH);
    checks++;
    if (out_valid !== 1'b1 || gcd_out !== 4'd0 || cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL zero_both_latch: ov=%0b gcd=%0d err=%0b required 1/0/0", out_valid, gcd_out, cmd_err);
    end
    consume();
  endtask

  task automatic test_errors();
    push(4'd3, 4'd7);
    do_cmd(CMD_LOAD);
    do_cmd(CMD_SUB_X);
    checks++;
    if (cmd_err !== 1'b1 || dut.x_reg !== 4'd3 || dut.y_reg !== 4'd7) begin
      failures++;
      $display("FAIL err_sub_x: err=%0b x=%0d y=%0d required 1/3/7", cmd_err, dut.x_reg, dut.y_reg);
    end
    idle();
    checks++;
    if (cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse_width: err=%0b required 0", cmd_err);
    end
    do_cmd(CMD_LOAD);
    checks++;
    if (cmd_err !== 1'b1 || dut.x_reg !== 4'd3 || dut.y_reg !== 4'd7) begin
      failures++;
      $display("FAIL err_load_empty: err=%0b x=%0d y=%0d required 1/3/7", cmd_err, dut.x_reg, dut.y_reg);
    end
    do_cmd(CMD_LATCH);
    checks++;
    if (cmd_err !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_latch_illegal: err=%0b ov=%0b required 1/0", cmd_err, out_valid);
    end
    do_cmd(3'd5);
    checks++;
    if (cmd_err !== 1'b1 || dut.x_reg !== 4'd3 || dut.y_reg !== 4'd7) begin
      failures++;
      $display("FAIL err_bad_code: err=%0b x=%0d y=%0d required 1/3/7", cmd_err, dut.x_reg, dut.y_reg);
    end
    do_cmd(CMD_SUB_Y);
    checks++;
    if (cmd_err !== 1'b0 || dut.y_reg !== 4'd4) begin
      failures++;
      $display("FAIL err_legal_sub_y: err=%0b y=%0d required 0/4", cmd_err, dut.y_reg);
    end
  endtask

  task automatic test_backpressure();
    push(4'd12, 4'd8);
    do_cmd(CMD_LOAD);
    do_cmd(CMD_SUB_X);
    do_cmd(CMD_SUB_Y);
    do_cmd(CMD_LATCH);
    push(4'd6, 4'd6);
    do_cmd(CMD_LOAD);
    do_cmd(CMD_LATCH);
    checks++;
    if (cmd_err !== 1'b1 || out_valid !== 1'b1 || gcd_out !== 4'd4 || iter_out !== 3'd2) begin
      failures++;
      $display("FAIL bp_blocked_latch: err=%0b ov=%0b gcd=%0d iter=%0d required 1/1/4/2",
               cmd_err, out_valid, gcd_out, iter_out);
    end
    out_ready = 1'b1;
    do_cmd(CMD_LATCH);
    out_ready = 1'b0;
    checks++;
    if (cmd_err !== 1'b0 || out_valid !== 1'b1 || gcd_out !== 4'd6 || iter_out !== 3'd0) begin
      failures++;
      $display("FAIL bp_replace: err=%0b ov=%0b gcd=%0d iter=%0d required 0/1/6/0",
               cmd_err, out_valid, gcd_out, iter_out);
    end
    consume();
  endtask

  task automatic test_saturation();
    push(4'd15, 4'd1);
    do_cmd(CMD_LOAD);
    for (int i = 0; i < 14; i++) do_cmd(CMD_SUB_X);
    checks++;
    if (dut.x_reg !== 4'd1 || x_eq_y !== 1'b1 || cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL sat_regs: x=%0d eq=%0b err=%0b required 1/1/0", dut.x_reg, x_eq_y, cmd_err);
    end
    do_cmd(CMD_LATCH);
    checks++;
    if (out_valid !== 1'b1 || gcd_out !== 4'd1 || iter_out !== 3'd7) begin
      failures++;
      $display("FAIL sat_latch: ov=%0b gcd=%0d iter=%0d required 1/1/7", out_valid, gcd_out, iter_out);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    push(4'd2, 4'd2);
    do_cmd(CMD_LOAD);
    do_cmd(CMD_LATCH);
    push(4'd5, 4'd10);
    checks++;
    if (op_pending !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_setup: pend=%0b ov=%0b required 1/1", op_pending, out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, op_pending, cmd_err, gcd_out, iter_out, x_eq_y, x_zero} !== {5'b0, 4'd0, 3'd0, 2'b11}) begin
      failures++;
      $display("FAIL mid_reset_clear: ov=%0b pend=%0b err=%0b gcd=%0d iter=%0d required 0/0/0/0/0",
               out_valid, op_pending, cmd_err, gcd_out, iter_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_pending !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_release: rdy=%0b ov=%0b pend=%0b required 1/0/0", in_ready, out_valid, op_pending);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_operands();
    test_errors();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
